// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with a 50% duty output for odd and even divisors.
// Divisor reloads and start/stop requests take effect only at period boundaries, so clk_out
// never glitches. The tick output is a one-cycle strobe at the start of each running period.
module clk_divider_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_err,
  output logic             div_busy,
  output logic [WIDTH-1:0] div_cur,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two    = WIDTH'(2);

  if ((longint'(DEFAULT_DIV) < 64'sd2) ||
      (longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 64'sd1))) begin : g_bad_default
    $error("DEFAULT_DIV must lie in 2..2^WIDTH-1");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  logic             clk_p_q, clk_p_d;
  logic             clk_n_q;
  logic             odd_q, odd_d;
  logic             tick_q, tick_d;
  logic             div_err_q, div_err_d;

  logic             boundary;
  logic [WIDTH-1:0] div_next;

  // Next-state: period counter, run/idle decision, divisor swap and load handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    odd_d      = odd_q;
    tick_d     = 1'b0;
    div_err_d  = 1'b0;

    // IDLE holds cnt at N-1, so every IDLE cycle is a boundary.
    boundary = (cnt_q == (div_cur_q - One));
    div_next = pending_q ? pend_val_q : div_cur_q;

    if (boundary) begin
      div_cur_d = div_next;
      pending_d = 1'b0;
      // Parity only changes here, where clk_p and clk_n are both low.
      odd_d     = div_next[0];
      if (en) begin
        state_d = StRun;
        cnt_d   = '0;
        tick_d  = 1'b1;
      end else begin
        state_d = StIdle;
        cnt_d   = div_next - One;
      end
    end else begin
      cnt_d = cnt_q + One;
    end

    // Evaluated after the boundary swap so a load on a boundary edge stays pending.
    if (div_load) begin
      if (div_in >= Two) begin
        pending_d  = 1'b1;
        pend_val_d = div_in;
      end else begin
        div_err_d = 1'b1;
      end
    end

    clk_p_d = (state_d == StRun) && (cnt_d < (div_cur_d >> 1));
  end

  // All posedge state, asynchronously cleared.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= DefDiv - One;
      div_cur_q  <= DefDiv;
      pend_val_q <= DefDiv;
      pending_q  <= 1'b0;
      clk_p_q    <= 1'b0;
      odd_q      <= 1'b0;
      tick_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      clk_p_q    <= clk_p_d;
      odd_q      <= odd_d;
      tick_q     <= tick_d;
      div_err_q  <= div_err_d;
    end
  end

  // Half-cycle delayed copy of clk_p, used to stretch the high phase for odd divisors.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_q;
    end
  end

  // Output selection: OR in the half-cycle extension only for odd divisors.
  always_comb begin
    clk_out  = clk_p_q | (odd_q & clk_n_q);
    tick     = tick_q;
    div_err  = div_err_q;
    div_busy = pending_q;
    div_cur  = div_cur_q;
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog. Stimulus pushes the expected shape of each output period
// (divisor, high and low length in half cycles) into a queue; a monitor sampling every half
// cycle pops one entry per clk_out rising edge and checks it.
module tb_clk_divider_prog;

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_err;
  logic       div_busy;
  logic [7:0] div_cur;
  logic       tick;
  logic       clk_out;

  int total = 0;
  int bad   = 0;
  int tick_count = 0;

  typedef struct {
    int n;
    int hi;
    int lo;  // 0: low phase not checked (stop or reset follows)
  } exp_t;

  exp_t exp_q[$];

  clk_divider_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(5)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .div_err (div_err),
    .div_busy(div_busy),
    .div_cur (div_cur),
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int n, input int hi, input int lo);
    exp_t e;
    e.n  = n;
    e.hi = hi;
    e.lo = lo;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int n, input int k);
    for (int i = 0; i < k; i++) push_exp(n, n, n);
  endtask

  // Returns 2 time units after the posedge that carried tick number t.
  task automatic wait_tick_to(input int t);
    for (int i = 0; i < 200; i++) begin
      if (tick_count >= t) break;
      @(posedge clk_in);
      #2;
    end
    check("tick_reached", int'(tick_count >= t), 1);
  endtask

  // Monitor: half-cycle samples of clk_out, one scoreboard entry per rising edge.
  initial begin
    logic prev_out;
    int   hi_cnt;
    int   lo_cnt;
    int   lo_exp;
    bit   lo_valid;
    bit   have_cur;
    exp_t cur;
    prev_out = 1'b0;
    hi_cnt   = 0;
    lo_cnt   = 0;
    lo_exp   = 0;
    lo_valid = 1'b0;
    have_cur = 1'b0;
    cur      = '{n: 0, hi: 0, lo: 0};
    forever begin
      @(clk_in);
      #1;
      if (clk_in && tick) tick_count++;
      if (clk_out && !prev_out) begin
        if (lo_valid && lo_exp != 0) check("low_width", lo_cnt, lo_exp);
        check("rise_expected", int'(exp_q.size() != 0), 1);
        check("tick_at_rise", int'(tick), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("div_cur_at_rise", int'(div_cur), cur.n);
        end else begin
          have_cur = 1'b0;
        end
        hi_cnt = 1;
      end else if (clk_out) begin
        hi_cnt++;
        if (clk_in && tick) check("stray_tick", int'(tick), 0);
      end else if (prev_out) begin
        if (have_cur) check("high_width", hi_cnt, cur.hi);
        lo_exp   = have_cur ? cur.lo : 0;
        lo_valid = 1'b1;
        lo_cnt   = 1;
      end else begin
        lo_cnt++;
        if (clk_in && tick) check("stray_tick", int'(tick), 0);
      end
      prev_out = clk_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_in   = 8'd0;
    div_load = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_div_cur", int'(div_cur), 5);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(div_busy), 0);
    check("rst_err", int'(div_err), 0);

    // Default divisor 5 from reset
    push_run(5, 4);
    en    = 1'b1;
    rst_n = 1'b1;
    wait_tick_to(4);

    // Load 4 mid-period: period 4 still 5 long, then 4
    push_run(4, 3);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd4;
    @(posedge clk_in);
    #1 check("busy_after_load", int'(div_busy), 1);
    @(negedge clk_in);
    div_load = 1'b0;
    wait_tick_to(5);
    check("busy_after_apply", int'(div_busy), 0);
    check("div_cur_4", int'(div_cur), 4);
    wait_tick_to(7);

    // Rejected loads of 1 and 0
    push_run(4, 2);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd1;
    @(posedge clk_in);
    #1 check("err_div1", int'(div_err), 1);
    @(negedge clk_in);
    div_load = 1'b0;
    @(posedge clk_in);
    #1 check("err_clear1", int'(div_err), 0);
    check("busy_bad_load1", int'(div_busy), 0);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd0;
    @(posedge clk_in);
    #1 check("err_div0", int'(div_err), 1);
    @(negedge clk_in);
    div_load = 1'b0;
    @(posedge clk_in);
    #1 check("err_clear0", int'(div_err), 0);
    check("busy_bad_load0", int'(div_busy), 0);
    check("div_cur_kept", int'(div_cur), 4);
    wait_tick_to(9);

    // Loads of 6 then 7 in one period: only 7 appears
    push_run(7, 2);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd6;
    @(negedge clk_in);
    div_in   = 8'd7;
    @(negedge clk_in);
    div_load = 1'b0;
    check("busy_two_loads", int'(div_busy), 1);
    wait_tick_to(11);

    // N=6, en dropped at cnt=1, then re-raised
    push_exp(6, 6, 0);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd6;
    @(negedge clk_in);
    div_load = 1'b0;
    wait_tick_to(12);
    @(posedge clk_in);
    @(negedge clk_in);
    en = 1'b0;
    repeat (12) @(posedge clk_in);
    #2;
    check("idle_no_tick", tick_count, 12);
    check("idle_clk_low", int'(clk_out), 0);
    push_run(6, 2);
    @(negedge clk_in);
    en = 1'b1;
    @(posedge clk_in);
    #1 check("restart_clk_high", int'(clk_out), 1);
    wait_tick_to(14);

    // N=9, reset in the high phase with a load pending
    push_exp(9, 3, 0);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd9;
    @(negedge clk_in);
    div_load = 1'b0;
    wait_tick_to(15);
    @(negedge clk_in);
    div_load = 1'b1;
    div_in   = 8'd3;
    @(posedge clk_in);
    #1 check("busy_before_reset", int'(div_busy), 1);
    #2;
    rst_n    = 1'b0;
    div_load = 1'b0;
    #1 check("reset_clk_low", int'(clk_out), 0);
    repeat (3) @(negedge clk_in);
    check("rst2_div_cur", int'(div_cur), 5);
    check("rst2_busy", int'(div_busy), 0);
    check("rst2_tick", int'(tick), 0);
    push_run(5, 2);
    push_exp(5, 5, 0);
    rst_n = 1'b1;
    wait_tick_to(18);
    @(negedge clk_in);
    en = 1'b0;
    repeat (15) @(posedge clk_in);
    #2;
    check("final_ticks", tick_count, 18);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_clk_low", int'(clk_out), 0);
    check("final_div_cur", int'(div_cur), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
